// File: rtl/hazard_stall_ctrl.sv
// Global stall / hold / bubble / flush generator for the in-order pipeline.
// Merges memory-wait freeze, load-use bubble and branch flush; counts stall cycles.
module hazard_stall_ctrl #(
   parameter int CNT_W = 32,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_read,
   input  logic             imem_resp,
   input  logic             dmem_read,
   input  logic             dmem_write,
   input  logic             dmem_resp,
   input  logic             id_ex_mem_read,
   input  logic [REG_W-1:0] id_ex_rd,
   input  logic [REG_W-1:0] if_id_rs1,
   input  logic [REG_W-1:0] if_id_rs2,
   input  logic             if_id_use_rs1,
   input  logic             if_id_use_rs2,
   input  logic             br_taken,
   output logic             stall,
   output logic             stall_front,
   output logic             bubble_id_ex,
   output logic             flush_if_id,
   output logic [CNT_W-1:0] mem_stall_cnt,
   output logic [CNT_W-1:0] lu_stall_cnt
);

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_LU_HOLD = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             i_done_q, i_done_d;
   logic             d_done_q, d_done_d;
   logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
   logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

   logic i_wait;
   logic d_wait;
   logic mem_stall;
   logic rs1_hit;
   logic rs2_hit;
   logic lu;
   logic br_flush;
   logic lu_bubble;

   // Gating with rst_n keeps every control output low during reset.
   always_comb begin
      i_wait    = imem_read & ~(imem_resp | i_done_q);
      d_wait    = (dmem_read | dmem_write) & ~(dmem_resp | d_done_q);
      mem_stall = rst_n & (i_wait | d_wait);
      rs1_hit   = if_id_use_rs1 & (if_id_rs1 == id_ex_rd);
      rs2_hit   = if_id_use_rs2 & (if_id_rs2 == id_ex_rd);
      lu        = id_ex_mem_read & (id_ex_rd != '0) & (rs1_hit | rs2_hit);
   end

   always_comb begin
      state_d   = state_q;
      br_flush  = 1'b0;
      lu_bubble = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (rst_n && !mem_stall) begin
               if (br_taken) begin
                  br_flush = 1'b1;
               end else if (lu) begin
                  lu_bubble = 1'b1;
                  state_d   = ST_LU_HOLD;
               end
            end
         end
         ST_LU_HOLD: begin
            if (!mem_stall) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // A response only becomes sticky while the other side still freezes us.
   always_comb begin
      i_done_d = mem_stall ? (i_done_q | imem_resp) : 1'b0;
      d_done_d = mem_stall ? (d_done_q | dmem_resp) : 1'b0;
   end

   always_comb begin
      mem_cnt_d = mem_cnt_q;
      lu_cnt_d  = lu_cnt_q;
      if (mem_stall && (mem_cnt_q != '1)) begin
         mem_cnt_d = mem_cnt_q + CNT_W'(1);
      end
      if (lu_bubble && (lu_cnt_q != '1)) begin
         lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         mem_cnt_q <= '0;
         lu_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         i_done_q  <= i_done_d;
         d_done_q  <= d_done_d;
         mem_cnt_q <= mem_cnt_d;
         lu_cnt_q  <= lu_cnt_d;
      end
   end

   assign stall         = mem_stall;
   assign stall_front   = mem_stall | lu_bubble;
   assign bubble_id_ex  = br_flush | lu_bubble;
   assign flush_if_id   = br_flush;
   assign mem_stall_cnt = mem_cnt_q;
   assign lu_stall_cnt  = lu_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, directed corner sequences,
// and random stimulus against a rule-level reference model.
module tb_hazard_stall_ctrl;

   localparam int CW  = 4;
   localparam int RW  = 5;
   localparam int MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          imem_read, imem_resp;
   logic          dmem_read, dmem_write, dmem_resp;
   logic          id_ex_mem_read;
   logic [RW-1:0] id_ex_rd, if_id_rs1, if_id_rs2;
   logic          if_id_use_rs1, if_id_use_rs2;
   logic          br_taken;
   logic          stall, stall_front, bubble_id_ex, flush_if_id;
   logic [CW-1:0] mem_stall_cnt, lu_stall_cnt;

   hazard_stall_ctrl #(.CNT_W(CW), .REG_W(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_read(imem_read), .imem_resp(imem_resp),
      .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_resp(dmem_resp), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
      .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1),
      .if_id_use_rs2(if_id_use_rs2), .br_taken(br_taken),
      .stall(stall), .stall_front(stall_front),
      .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
      .mem_stall_cnt(mem_stall_cnt), .lu_stall_cnt(lu_stall_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference model: sticky response bits, a "bubble was just issued" bit,
   // and plain integer counters clamped at MAX.
   bit m_igot, m_dgot, m_after_bubble;
   int m_mem, m_lu;
   bit e_stall, e_front, e_bub, e_flush, e_lub;

   task automatic model_clear();
      m_igot = 0; m_dgot = 0; m_after_bubble = 0; m_mem = 0; m_lu = 0;
   endtask

   task automatic model_eval();
      bit iw, dw, haz, free;
      iw = imem_read && !(imem_resp || m_igot);
      dw = (dmem_read || dmem_write) && !(dmem_resp || m_dgot);
      e_stall = iw || dw;
      haz = id_ex_mem_read && (id_ex_rd != 0) &&
            ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) ||
             (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
      free = !e_stall && !m_after_bubble;
      e_flush = free && br_taken;
      e_lub   = free && !br_taken && haz;
      e_bub   = e_flush || e_lub;
      e_front = e_stall || e_lub;
   endtask

   task automatic model_step();
      if (e_stall) begin
         m_igot = m_igot || imem_resp;
         m_dgot = m_dgot || dmem_resp;
         if (m_mem < MAX) m_mem++;
      end else begin
         m_igot = 0;
         m_dgot = 0;
      end
      if (e_lub && m_lu < MAX) m_lu++;
      m_after_bubble = e_lub || (m_after_bubble && e_stall);
   endtask

   task automatic idle_inputs();
      imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0;
      dmem_resp = 0; id_ex_mem_read = 0; id_ex_rd = 0; if_id_rs1 = 0;
      if_id_rs2 = 0; if_id_use_rs1 = 0; if_id_use_rs2 = 0; br_taken = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_clear();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Inputs are driven just after posedge; compared at the negedge.
   task automatic cycle();
      model_eval();
      @(negedge clk);
      chk("stall", 32'(stall), 32'(e_stall));
      chk("stall_front", 32'(stall_front), 32'(e_front));
      chk("bubble_id_ex", 32'(bubble_id_ex), 32'(e_bub));
      chk("flush_if_id", 32'(flush_if_id), 32'(e_flush));
      chk("mem_stall_cnt", 32'(mem_stall_cnt), 32'(m_mem));
      chk("lu_stall_cnt", 32'(lu_stall_cnt), 32'(m_lu));
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic ir, irs, dr, dw, drs, mr;
      logic [RW-1:0] rd, rs1, rs2;
      logic u1, u2, br;
      logic x_stall, x_front, x_bub, x_flush;
   } vec_t;

   vec_t vt[13];

   initial begin
      vt[0]  = '{0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0};
      vt[1]  = '{1,0,0,0,0, 0,0,0,0, 0,0,0, 1,1,0,0};
      vt[2]  = '{1,1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0};
      vt[3]  = '{0,0,0,1,0, 0,0,0,0, 0,0,0, 1,1,0,0};
      vt[4]  = '{0,0,0,1,1, 0,0,0,0, 0,0,0, 0,0,0,0};
      vt[5]  = '{0,0,0,0,0, 1,5,5,0, 1,0,0, 0,1,1,0};
      vt[6]  = '{0,0,0,0,0, 1,5,5,0, 0,0,0, 0,0,0,0};
      vt[7]  = '{0,0,0,0,0, 1,0,0,0, 1,1,0, 0,0,0,0};
      vt[8]  = '{0,0,0,0,0, 1,5,5,0, 1,0,1, 0,0,1,1};
      vt[9]  = '{1,0,0,0,0, 1,5,5,0, 1,0,0, 1,1,0,0};
      vt[10] = '{0,0,1,0,0, 0,0,0,0, 0,0,1, 1,1,0,0};
      vt[11] = '{0,0,0,0,0, 1,7,3,7, 1,1,0, 0,1,1,0};
      vt[12] = '{0,0,0,0,0, 0,0,0,0, 0,0,1, 0,0,1,1};

      idle_inputs();
      rst_n = 1'b0;
      model_clear();
      #2;
      imem_read = 1; br_taken = 1;
      #1;
      chk("rst_stall", 32'(stall), 0);
      chk("rst_flush", 32'(flush_if_id), 0);
      chk("rst_cnt", 32'(mem_stall_cnt), 0);
      do_reset();

      foreach (vt[i]) begin
         do_reset();
         imem_read = vt[i].ir; imem_resp = vt[i].irs;
         dmem_read = vt[i].dr; dmem_write = vt[i].dw;
         dmem_resp = vt[i].drs; id_ex_mem_read = vt[i].mr;
         id_ex_rd = vt[i].rd; if_id_rs1 = vt[i].rs1;
         if_id_rs2 = vt[i].rs2; if_id_use_rs1 = vt[i].u1;
         if_id_use_rs2 = vt[i].u2; br_taken = vt[i].br;
         @(negedge clk);
         chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].x_stall));
         chk($sformatf("vec%0d_front", i), 32'(stall_front), 32'(vt[i].x_front));
         chk($sformatf("vec%0d_bub", i), 32'(bubble_id_ex), 32'(vt[i].x_bub));
         chk($sformatf("vec%0d_flush", i), 32'(flush_if_id), 32'(vt[i].x_flush));
         @(posedge clk);
         #1;
      end

      // fetch-only miss
      do_reset();
      imem_read = 1;
      repeat (3) cycle();
      imem_resp = 1;
      #1 chk("fetch_resp_stall", 32'(stall), 0);
      cycle();
      idle_inputs();
      chk("fetch_cnt", 32'(mem_stall_cnt), 3);
      cycle();

      // split I/D responses
      do_reset();
      imem_read = 1; dmem_read = 1;
      cycle();
      imem_resp = 1;
      #1 chk("split_c1_stall", 32'(stall), 1);
      cycle();
      imem_resp = 0;
      #1 chk("split_c2_stall", 32'(stall), 1);
      cycle();
      cycle();
      dmem_resp = 1;
      #1 chk("split_c4_stall", 32'(stall), 0);
      cycle();
      dmem_resp = 0;
      #1 chk("split_c5_fresh", 32'(stall), 1);
      chk("split_cnt", 32'(mem_stall_cnt), 4);
      idle_inputs();
      cycle();

      // load-use then suppressed hold cycle
      do_reset();
      id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs2 = 5; if_id_use_rs2 = 1;
      #1 chk("lu_front", 32'(stall_front), 1);
      chk("lu_bub", 32'(bubble_id_ex), 1);
      cycle();
      chk("lu_hold_front", 32'(stall_front), 0);
      chk("lu_hold_bub", 32'(bubble_id_ex), 0);
      cycle();
      idle_inputs();
      chk("lu_cnt", 32'(lu_stall_cnt), 1);
      cycle();

      // hazard on x0
      do_reset();
      id_ex_mem_read = 1; id_ex_rd = 0; if_id_rs2 = 0; if_id_use_rs2 = 1;
      #1 chk("x0_bub", 32'(bubble_id_ex), 0);
      cycle();
      chk("x0_cnt", 32'(lu_stall_cnt), 0);

      // branch beats load-use
      do_reset();
      id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs2 = 5; if_id_use_rs2 = 1;
      br_taken = 1;
      #1 chk("br_lu_flush", 32'(flush_if_id), 1);
      chk("br_lu_bub", 32'(bubble_id_ex), 1);
      chk("br_lu_front", 32'(stall_front), 0);
      cycle();
      chk("br_lu_cnt", 32'(lu_stall_cnt), 0);
      idle_inputs();

      // async reset while d_done is set and fetch still waits
      do_reset();
      dmem_read = 1;
      cycle();
      dmem_resp = 1; imem_read = 1;
      cycle();
      dmem_resp = 0;
      #1 chk("pre_rst_stall", 32'(stall), 1);
      br_taken = 1;
      #2 rst_n = 1'b0;
      model_clear();
      #1 chk("mid_rst_stall", 32'(stall), 0);
      chk("mid_rst_front", 32'(stall_front), 0);
      chk("mid_rst_flush", 32'(flush_if_id), 0);
      chk("mid_rst_cnt", 32'(mem_stall_cnt), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle_inputs();
      dmem_read = 1;
      #1 chk("post_rst_fresh", 32'(stall), 1);
      cycle();
      idle_inputs();

      // saturation of both counters
      do_reset();
      imem_read = 1;
      repeat (MAX + 5) cycle();
      chk("mem_sat", 32'(mem_stall_cnt), MAX);
      do_reset();
      id_ex_mem_read = 1; id_ex_rd = 9; if_id_rs1 = 9; if_id_use_rs1 = 1;
      repeat (2 * MAX + 8) cycle();
      chk("lu_sat", 32'(lu_stall_cnt), MAX);

      // random traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         imem_read = ($urandom_range(0, 1) == 1);
         imem_resp = ($urandom_range(0, 2) == 0);
         dmem_read = ($urandom_range(0, 3) == 0);
         dmem_write = ($urandom_range(0, 4) == 0);
         dmem_resp = ($urandom_range(0, 2) == 0);
         id_ex_mem_read = ($urandom_range(0, 1) == 1);
         id_ex_rd = RW'($urandom_range(0, 3));
         if_id_rs1 = RW'($urandom_range(0, 3));
         if_id_rs2 = RW'($urandom_range(0, 3));
         if_id_use_rs1 = ($urandom_range(0, 1) == 1);
         if_id_use_rs2 = ($urandom_range(0, 1) == 1);
         br_taken = ($urandom_range(0, 5) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
